// File: rtl/mips_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_alu_pkg                                                    |
// | Purpose  : ALU op codes, MIPS opcode/funct constants, decoded control type |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       use_imm;
        logic       sign_ext;
        logic       dest_rd;
        logic       reads_rt;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       illegal;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_ctrl_decode                                                 |
// | Purpose  : Combinational MIPS opcode/funct to ALU control bundle decode    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_ctrl_decode
    import mips_alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dest_rd  = 1'b1;
                ctrl.reads_rt = 1'b1;
                ctrl.reg_wr   = 1'b1;
                case (funct)
                    FN_AND:          ctrl.alu_op = ALU_AND;
                    FN_OR:           ctrl.alu_op = ALU_OR;
                    FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_SLT:          ctrl.alu_op = ALU_SLT;
                    default:         ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.alu_op   = ALU_ADD;
                ctrl.use_imm  = 1'b1;
                ctrl.sign_ext = 1'b1;
                ctrl.reg_wr   = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_op  = ALU_AND;
                ctrl.use_imm = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OP_ORI: begin
                ctrl.alu_op  = ALU_OR;
                ctrl.use_imm = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_op   = ALU_SLT;
                ctrl.use_imm  = 1'b1;
                ctrl.sign_ext = 1'b1;
                ctrl.reg_wr   = 1'b1;
            end
            // The ALU does the 16-bit shift; the immediate goes in unshifted.
            OP_LUI: begin
                ctrl.alu_op  = ALU_LUI;
                ctrl.use_imm = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_op   = ALU_ADD;
                ctrl.use_imm  = 1'b1;
                ctrl.sign_ext = 1'b1;
                ctrl.reg_wr   = 1'b1;
                ctrl.mem_rd   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op   = ALU_ADD;
                ctrl.use_imm  = 1'b1;
                ctrl.sign_ext = 1'b1;
                ctrl.reads_rt = 1'b1;
                ctrl.mem_wr   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op   = ALU_SUB;
                ctrl.reads_rt = 1'b1;
                ctrl.branch   = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_stage                                                 |
// | Purpose  : ID/EX register feeding the ALU; decode, operand select,         |
// |            forwarding and load-use bubble (forwarding: ALU_ISSUE_FWD_EN)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_issue_stage
    import mips_alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [31:0]   id_instr,
    input  logic [DW-1:0] rf_rs_data,
    input  logic [DW-1:0] rf_rt_data,
    input  logic          stall,
    input  logic          flush,
    input  logic          exm_wr,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_data,
    input  logic          mwb_wr,
    input  logic [RW-1:0] mwb_rd,
    input  logic [DW-1:0] mwb_data,
    output logic          ex_valid,
    output logic [2:0]    ex_alu_op,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_wr,
    output logic          ex_mem_rd,
    output logic          ex_mem_wr,
    output logic          ex_branch,
    output logic          id_illegal,
    output logic          load_use_stall
);

    ctrl_t         ctrl;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [15:0]   imm;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [RW-1:0] dest;
    logic          bubble;

    assign rs_idx = id_instr[25:21];
    assign rt_idx = id_instr[20:16];
    assign rd_idx = id_instr[15:11];
    assign imm    = id_instr[15:0];

    alu_ctrl_decode u_decode (
        .opcode (id_instr[31:26]),
        .funct  (id_instr[5:0]),
        .ctrl   (ctrl)
    );

    assign id_illegal = id_valid & ctrl.illegal;
    assign imm_ext    = ctrl.sign_ext ? {{(DW-16){imm[15]}}, imm} : {{(DW-16){1'b0}}, imm};
    assign dest       = ctrl.dest_rd ? rd_idx : rt_idx;

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] idx,
                                              input logic [DW-1:0] rf_val,
                                              input logic          e_wr,
                                              input logic [RW-1:0] e_rd,
                                              input logic [DW-1:0] e_data,
                                              input logic          m_wr,
                                              input logic [RW-1:0] m_rd,
                                              input logic [DW-1:0] m_data);
        if (idx == '0)
            return '0;
        else if (e_wr && (e_rd == idx))
            return e_data;
        else if (m_wr && (m_rd == idx))
            return m_data;
        else
            return rf_val;
    endfunction

    assign rs_val = fwd_sel(rs_idx, rf_rs_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);
    assign rt_val = fwd_sel(rt_idx, rf_rt_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);

    // A load still in EX has no data to forward yet, so its consumer must wait a cycle.
    assign load_use_stall = ex_valid & ex_mem_rd & (ex_dest != '0) & id_valid &
                            ((ex_dest == rs_idx) | (ctrl.reads_rt & (ex_dest == rt_idx)));
`else
    logic unused_fwd;
    assign unused_fwd     = ^{exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data, ctrl.reads_rt};
    assign rs_val         = rf_rs_data;
    assign rt_val         = rf_rt_data;
    assign load_use_stall = 1'b0;
`endif

    assign bubble = flush | load_use_stall;

    always_ff @(posedge clk) begin
        if (!rst_n || bubble || (!stall && (!id_valid || ctrl.illegal))) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= ALU_AND;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_dest       <= '0;
            ex_reg_wr     <= 1'b0;
            ex_mem_rd     <= 1'b0;
            ex_mem_wr     <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= ctrl.alu_op;
            ex_a          <= rs_val;
            ex_b          <= ctrl.use_imm ? imm_ext : rt_val;
            ex_store_data <= rt_val;
            ex_dest       <= dest;
            ex_reg_wr     <= ctrl.reg_wr;
            ex_mem_rd     <= ctrl.mem_rd;
            ex_mem_wr     <= ctrl.mem_wr;
            ex_branch     <= ctrl.branch;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_issue_stage                                              |
// | Purpose  : Directed self-checking bench for alu_issue_stage                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic        stall;
    logic        flush;
    logic        exm_wr;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_wr;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic        ex_valid;
    logic [2:0]  ex_alu_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_branch;
    logic        id_illegal;
    logic        load_use_stall;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DW(32), .RW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .rf_rs_data     (rf_rs_data),
        .rf_rt_data     (rf_rt_data),
        .stall          (stall),
        .flush          (flush),
        .exm_wr         (exm_wr),
        .exm_rd         (exm_rd),
        .exm_data       (exm_data),
        .mwb_wr         (mwb_wr),
        .mwb_rd         (mwb_rd),
        .mwb_data       (mwb_data),
        .ex_valid       (ex_valid),
        .ex_alu_op      (ex_alu_op),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_store_data  (ex_store_data),
        .ex_dest        (ex_dest),
        .ex_reg_wr      (ex_reg_wr),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .ex_branch      (ex_branch),
        .id_illegal     (id_illegal),
        .load_use_stall (load_use_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic no_fwd();
        exm_wr = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
        mwb_wr = 1'b0; mwb_rd = 5'd0; mwb_data = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0;
        rf_rs_data = 32'd0; rf_rt_data = 32'd0; stall = 1'b0; flush = 1'b0;
        no_fwd();
        tick(); tick();
        rst_n = 1'b1;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_op",    {29'd0, ex_alu_op}, 32'd0);
        check("rst_a",     ex_a, 32'd0);
        check("rst_regwr", {31'd0, ex_reg_wr}, 32'd0);

        // add $3,$1,$2
        id_valid = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
        rf_rs_data = 32'd5; rf_rt_data = 32'd7;
        #1 check("add_illegal", {31'd0, id_illegal}, 32'd0);
        tick();
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_op",    {29'd0, ex_alu_op}, 32'd2);
        check("add_a",     ex_a, 32'd5);
        check("add_b",     ex_b, 32'd7);
        check("add_dest",  {27'd0, ex_dest}, 32'd3);
        check("add_regwr", {31'd0, ex_reg_wr}, 32'd1);

        // andi $4,$1,0xFFFF then slti $4,$1,0xFFFF
        id_instr = itype(6'b001100, 5'd1, 5'd4, 16'hFFFF); rf_rs_data = 32'h12345678;
        tick();
        check("andi_op",   {29'd0, ex_alu_op}, 32'd0);
        check("andi_a",    ex_a, 32'h12345678);
        check("andi_b",    ex_b, 32'h0000FFFF);
        check("andi_dest", {27'd0, ex_dest}, 32'd4);
        id_instr = itype(6'b001010, 5'd1, 5'd4, 16'hFFFF);
        tick();
        check("slti_op", {29'd0, ex_alu_op}, 32'd7);
        check("slti_b",  ex_b, 32'hFFFFFFFF);

        // sub $5,$1,$2 with both forwarding paths hitting rs
        id_instr = rtype(5'd1, 5'd2, 5'd5, 6'b100010);
        rf_rs_data = 32'h11; rf_rt_data = 32'h22;
        exm_wr = 1'b1; exm_rd = 5'd1; exm_data = 32'd9;
        mwb_wr = 1'b1; mwb_rd = 5'd1; mwb_data = 32'd4;
        tick();
        check("sub_op", {29'd0, ex_alu_op}, 32'd6);
`ifdef ALU_ISSUE_FWD_EN
        check("fwd_exm_a", ex_a, 32'd9);
`else
        check("fwd_exm_a", ex_a, 32'h11);
`endif
        check("fwd_b_rf", ex_b, 32'h22);
        exm_rd = 5'd0; mwb_rd = 5'd0;
        tick();
        check("fwd_rd0_a", ex_a, 32'h11);
        exm_wr = 1'b0; mwb_rd = 5'd2;
        tick();
        check("fwd_mwb_a", ex_a, 32'h11);
`ifdef ALU_ISSUE_FWD_EN
        check("fwd_mwb_b", ex_b, 32'd4);
`else
        check("fwd_mwb_b", ex_b, 32'h22);
`endif
        no_fwd();

        // register 0 source
        id_instr = rtype(5'd0, 5'd2, 5'd5, 6'b100000);
        rf_rs_data = 32'd0;
        exm_wr = 1'b1; exm_rd = 5'd0; exm_data = 32'hDEAD;
        tick();
        check("r0_a", ex_a, 32'd0);
        no_fwd();

        // lw $2,0($1) then add $3,$2,$2
        id_instr = itype(6'b100011, 5'd1, 5'd2, 16'd0); rf_rs_data = 32'h100;
        tick();
        check("lw_memrd", {31'd0, ex_mem_rd}, 32'd1);
        check("lw_dest",  {27'd0, ex_dest}, 32'd2);
        check("lw_b",     ex_b, 32'd0);
        id_instr = rtype(5'd2, 5'd2, 5'd3, 6'b100000);
        rf_rs_data = 32'h77; rf_rt_data = 32'h77;
        mwb_wr = 1'b1; mwb_rd = 5'd2; mwb_data = 32'h55;
        #1;
`ifdef ALU_ISSUE_FWD_EN
        check("lu_stall", {31'd0, load_use_stall}, 32'd1);
        tick();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_clear",  {31'd0, load_use_stall}, 32'd0);
        tick();
        check("lu_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_a",     ex_a, 32'h55);
        check("lu_b",     ex_b, 32'h55);
`else
        check("lu_stall", {31'd0, load_use_stall}, 32'd0);
        tick();
        check("lu_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_a",     ex_a, 32'h77);
`endif
        no_fwd();

        // sw $2,4($1), beq, lui
        id_instr = itype(6'b101011, 5'd1, 5'd2, 16'd4);
        rf_rs_data = 32'h10; rf_rt_data = 32'hAB;
        tick();
        check("sw_memwr", {31'd0, ex_mem_wr}, 32'd1);
        check("sw_regwr", {31'd0, ex_reg_wr}, 32'd0);
        check("sw_b",     ex_b, 32'd4);
        check("sw_sdata", ex_store_data, 32'hAB);
        id_instr = itype(6'b000100, 5'd1, 5'd2, 16'hFFFE);
        tick();
        check("beq_br", {31'd0, ex_branch}, 32'd1);
        check("beq_op", {29'd0, ex_alu_op}, 32'd6);
        check("beq_b",  ex_b, 32'hAB);
        id_instr = itype(6'b001111, 5'd0, 5'd7, 16'h8000);
        tick();
        check("lui_op", {29'd0, ex_alu_op}, 32'd3);
        check("lui_b",  ex_b, 32'h00008000);

        // stall hold then flush+stall
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
        rf_rs_data = 32'd5; rf_rt_data = 32'd7;
        tick();
        stall = 1'b1;
        id_instr = rtype(5'd4, 5'd5, 5'd6, 6'b100101);
        rf_rs_data = 32'hAA; rf_rt_data = 32'hBB;
        tick(); tick(); tick();
        check("stall_a",    ex_a, 32'd5);
        check("stall_op",   {29'd0, ex_alu_op}, 32'd2);
        check("stall_dest", {27'd0, ex_dest}, 32'd3);
        flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_regwr", {31'd0, ex_reg_wr}, 32'd0);
        check("flush_op",    {29'd0, ex_alu_op}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // id_valid low gives a bubble
        tick();
        check("or_op", {29'd0, ex_alu_op}, 32'd1);
        id_valid = 1'b0;
        tick();
        check("novalid_bubble", {31'd0, ex_valid}, 32'd0);
        id_valid = 1'b1;

        // illegal opcode
        id_instr = itype(6'b111111, 5'd1, 5'd2, 16'd0);
        #1 check("ill_flag", {31'd0, id_illegal}, 32'd1);
        tick();
        check("ill_valid", {31'd0, ex_valid}, 32'd0);
        check("ill_regwr", {31'd0, ex_reg_wr}, 32'd0);

        // reset while stalled
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
        rf_rs_data = 32'd5; rf_rt_data = 32'd7;
        tick();
        check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b1; rst_n = 1'b0;
        tick();
        check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_a",     ex_a, 32'd0);
        check("mid_rst_b",     ex_b, 32'd0);
        check("mid_rst_dest",  {27'd0, ex_dest}, 32'd0);
        check("mid_rst_regwr", {31'd0, ex_reg_wr}, 32'd0);
        rst_n = 1'b1; stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
